// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: parses a counted little-endian word
// stream, writes each word to instruction memory, and verifies a trailing checksum.
module imem_loader #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [8:0]  words_written
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_LO, S_HDR_HI, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  count_lo_q, count_lo_d;
  logic [8:0]  count_q, count_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] word_buf_q, word_buf_d;
  logic [7:0]  mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [7:0]  csum_q, csum_d;
  logic [8:0]  words_written_q, words_written_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic       xfer;
  logic [8:0] hdr_count;

  assign hdr_count = {in_data[0], count_lo_q};

  always_comb begin
    in_ready = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) ||
               (state_q == S_DATA)   || (state_q == S_CHECK);
    busy     = !((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR));
    // Abort must kill a strobe already in its WRITE cycle, so it gates mem_we directly.
    mem_we   = (state_q == S_WRITE) && !abort;
    xfer     = in_valid && in_ready;
  end

  // NOTE: every *_d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    state_d         = state_q;
    count_lo_d      = count_lo_q;
    count_d         = count_q;
    byte_idx_d      = byte_idx_q;
    word_buf_d      = word_buf_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    csum_d          = csum_q;
    words_written_d = words_written_q;
    done_d          = done_q;
    error_d         = error_q;

    if (abort) begin
      // Abort outranks start, and only busy states have anything to abandon.
      if (busy) begin
        state_d = S_IDLE;
        done_d  = 1'b0;
        error_d = 1'b0;
      end
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_d         = S_HDR_LO;
            done_d          = 1'b0;
            error_d         = 1'b0;
            words_written_d = '0;
            csum_d          = '0;
            byte_idx_d      = '0;
          end
        end
        S_HDR_LO: begin
          if (xfer) begin
            count_lo_d = in_data;
            state_d    = S_HDR_HI;
          end
        end
        S_HDR_HI: begin
          if (xfer) begin
            if ((in_data[7:1] == 7'd0) && (hdr_count != 9'd0) && (hdr_count <= 9'(DEPTH))) begin
              count_d    = hdr_count;
              byte_idx_d = '0;
              state_d    = S_DATA;
            end else begin
              error_d = 1'b1;
              state_d = S_ERROR;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            csum_d     = csum_q + in_data;
            byte_idx_d = byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0: word_buf_d[7:0]   = in_data;
              2'd1: word_buf_d[15:8]  = in_data;
              2'd2: word_buf_d[23:16] = in_data;
              default: begin
                mem_wdata_d = {in_data, word_buf_q};
                mem_addr_d  = words_written_q[7:0];
                state_d     = S_WRITE;
              end
            endcase
          end
        end
        S_WRITE: begin
          words_written_d = words_written_q + 9'd1;
          state_d         = (words_written_q + 9'd1 == count_q) ? S_CHECK : S_DATA;
        end
        S_CHECK: begin
          if (xfer) begin
            if (in_data == csum_q) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              error_d = 1'b1;
              state_d = S_ERROR;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      count_lo_q      <= '0;
      count_q         <= '0;
      byte_idx_q      <= '0;
      word_buf_q      <= '0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      csum_q          <= '0;
      words_written_q <= '0;
      done_q          <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_lo_q      <= count_lo_d;
      count_q         <= count_d;
      byte_idx_q      <= byte_idx_d;
      word_buf_q      <= word_buf_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      csum_q          <= csum_d;
      words_written_q <= words_written_d;
      done_q          <= done_d;
      error_q         <= error_d;
    end
  end

  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign done          = done_q;
  assign error         = error_q;
  assign words_written = words_written_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and randomized byte streams
// compared against a stream-level reference model.
module tb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [8:0]  words_written;

  imem_loader #(.DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .words_written(words_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Stimulus stream and model results
  logic [7:0]  stim[$];
  logic [39:0] exp_q[$];
  logic [39:0] got_q[$];
  int          n_accept;
  bit          exp_done, exp_err;
  int          exp_ww;

  // Monitor: capture writes and check their timing against byte acceptance
  int cyc = 0;
  int last_xfer_cyc = -10;
  int last_xfer_idx = -1;
  int xfer_idx = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      if (start && !abort && !busy) xfer_idx = 0;
      if (mem_we) begin
        got_q.push_back({mem_addr, mem_wdata});
        check("we_in_ready", in_ready, 0);
        check("we_latency", cyc - last_xfer_cyc, 1);
        check("we_byte_pos", last_xfer_idx, 4 * int'(mem_addr) + 5);
        check("ww_during_write", words_written, mem_addr);
      end
      if (in_valid && in_ready) begin
        last_xfer_cyc = cyc;
        last_xfer_idx = xfer_idx;
        xfer_idx++;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

  // Reference model: derives writes and outcome from the stream rules alone
  task automatic model();
    logic [8:0]  cnt;
    logic [7:0]  sum;
    logic [31:0] w;
    exp_q.delete();
    cnt = {stim[1][0], stim[0]};
    if (stim[1][7:1] != 7'd0 || cnt == 9'd0 || cnt > 9'd256) begin
      n_accept = 2; exp_done = 0; exp_err = 1; exp_ww = 0;
    end else begin
      sum = 8'd0;
      for (int i = 0; i < int'(cnt); i++) begin
        w = {stim[2+4*i+3], stim[2+4*i+2], stim[2+4*i+1], stim[2+4*i]};
        exp_q.push_back({i[7:0], w});
        for (int k = 0; k < 4; k++) sum = sum + stim[2+4*i+k];
      end
      n_accept = 2 + 4 * int'(cnt) + 1;
      exp_done = (stim[n_accept-1] == sum);
      exp_err  = !exp_done;
      exp_ww   = int'(cnt);
    end
  endtask

  task automatic build_stream(input int n, input bit bad);
    logic [8:0]  c;
    logic [7:0]  sum;
    logic [31:0] w;
    c = n[8:0];
    stim.delete();
    stim.push_back(c[7:0]);
    stim.push_back({7'd0, c[8]});
    sum = 8'd0;
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      for (int k = 0; k < 4; k++) begin
        stim.push_back(w[8*k +: 8]);
        sum = sum + w[8*k +: 8];
      end
    end
    if (bad) sum = sum + 8'($urandom_range(1, 255));
    stim.push_back(sum);
  endtask

  task automatic set_two_word(input logic [7:0] csum);
    stim = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00, csum};
  endtask

  // Driver tasks are entered and left one time unit after a rising edge
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    bit ok;
    int gap;
    gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = b;
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) check("handshake_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = !busy;
    end
    @(posedge clk); #1;
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  task automatic run_session(input string tag, input int gap_max);
    int base;
    model();
    base = got_q.size();
    pulse_start();
    for (int i = 0; i < n_accept; i++) send_byte(stim[i], gap_max);
    wait_idle();
    check({tag, "_done"}, done, exp_done);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ww"}, words_written, exp_ww);
    check({tag, "_nwrites"}, got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < got_q.size()) check({tag, "_write"}, got_q[base+i], exp_q[i]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_ww"}, words_written, 0);
  endtask

  initial begin
    int base;
    int n;
    int kind;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #3;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two-word load with good, then bad checksum
    set_two_word(8'hD7);
    run_session("two_word", 0);
    check("two_word_w0", got_q[got_q.size()-2], {8'd0, 32'h00100093});
    check("two_word_w1", got_q[got_q.size()-1], {8'd1, 32'h00200113});
    set_two_word(8'hD6);
    run_session("bad_csum", 0);

    // Illegal and boundary headers
    stim = '{8'h00, 8'h00};
    run_session("hdr_zero", 0);
    stim = '{8'h00, 8'h02};
    run_session("hdr_big", 0);
    build_stream(256, 0);
    run_session("hdr_256", 0);

    // Same two-word stream with random in_valid gaps
    for (int r = 0; r < 3; r++) begin
      set_two_word(8'hD7);
      run_session("gaps", 4);
    end

    // Abort on the cycle the last byte of word 1 is accepted
    set_two_word(8'hD7);
    base = got_q.size();
    pulse_start();
    for (int i = 0; i < 9; i++) send_byte(stim[i], 0);
    in_valid = 1'b1; in_data = stim[9]; abort = 1'b1;
    @(negedge clk);
    check("abort_ready", in_ready, 1);
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_error", error, 0);
    check("abort_we", mem_we, 0);
    repeat (4) begin @(posedge clk); #1; end
    check("abort_nwrites", got_q.size() - base, 1);

    // Start and abort together from IDLE
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_ready", in_ready, 0);

    // Reset mid-payload, then a clean session
    build_stream(3, 0);
    pulse_start();
    for (int i = 0; i < 12; i++) send_byte(stim[i], 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_two_word(8'hD7);
    run_session("after_reset", 0);

    // Randomized sessions: good, bad checksum, illegal header
    for (int r = 0; r < 8; r++) begin
      n = int'($urandom_range(1, 6));
      kind = int'($urandom_range(0, 3));
      if (kind == 0) begin
        stim.delete();
        stim.push_back(8'($urandom));
        stim.push_back({7'($urandom_range(1, 127)), 1'($urandom)});
      end else begin
        build_stream(n, kind == 1);
      end
      run_session("rand", 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
